// File: rtl/day_time_pkg.sv
// Shared definitions for the digital clock time-set path: converter FSM
// states, BCD hour constants and the load-acknowledge timeout counter width.
package day_time_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_CONV  = 2'd2,
    ST_LOAD  = 2'd3
  } conv_state_t;

  localparam logic [7:0] HOUR_NOON     = 8'h12;
  localparam logic [7:0] HOUR_MIDNIGHT = 8'h00;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  localparam int unsigned ACK_CNT_W = 8;

  // A 12-hour reading is legal only for 01..12 with both digits in BCD range.
  function automatic logic is_valid_hour12(input logic [3:0] ht, input logic [3:0] hu);
    logic ok;
    ok = 1'b0;
    if ((ht <= BCD_MAX_DIGIT) && (hu <= BCD_MAX_DIGIT)) begin
      if (ht == 4'd0) begin
        ok = (hu != 4'd0);
      end else if (ht == 4'd1) begin
        ok = (hu <= 4'd2);
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_hour_add12.sv
// Adds twelve hours to a BCD hour (01..11 -> 13..23). Purely combinational,
// shared with the time-set logic.
module bcd_hour_add12
  import day_time_pkg::*;
(
  input  logic [3:0] i_ht,
  input  logic [3:0] i_hu,
  output logic [3:0] o_ht,
  output logic [3:0] o_hu
);

  logic [3:0] w_units_sum;
  logic       w_carry;

  // Units get +2 with decimal wrap; tens get +1 plus the units carry.
  always_comb begin
    w_units_sum = i_hu + 4'd2;
    w_carry     = (w_units_sum > BCD_MAX_DIGIT);
    o_hu        = w_carry ? (w_units_sum - 4'd10) : w_units_sum;
    o_ht        = i_ht + 4'd1 + {3'b000, w_carry};
  end

endmodule

// File: rtl/day12_24.sv
// 12-hour to 24-hour BCD hour converter with load/ack handoff to the hour
// counter. Optional ack timeout: define DAY12_ACK_TIMEOUT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; inputs captured on the accepting edge
// ST_CHECK | validate captured hour, err pulse and back to idle if bad
// ST_CONV  | register the 24-hour result onto bcd_hto/bcd_huo
// ST_LOAD  | hold load until load_ack (or timeout when enabled)
module day12_24
  import day_time_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] bcd_ht,
  input  logic [3:0] bcd_hu,
  input  logic       pm,
  input  logic       load_ack,
  output logic       busy,
  output logic       load,
  output logic       done,
  output logic       err,
  output logic [3:0] bcd_hto,
  output logic [3:0] bcd_huo
);

  if ((ACK_TIMEOUT < 1) || (ACK_TIMEOUT > ((2 ** ACK_CNT_W) - 1))) begin : g_bad_timeout
    $error("day12_24: ACK_TIMEOUT out of range");
  end

  conv_state_t r_state;
  conv_state_t w_state_nxt;

  logic [3:0] r_ht;
  logic [3:0] r_hu;
  logic       r_pm;
  logic [3:0] r_hto;
  logic [3:0] r_huo;
  logic       r_done;
  logic       r_err;

  logic       w_capture;
  logic       w_done_nxt;
  logic       w_err_nxt;
  logic       w_timeout;
  logic [3:0] w_add_ht;
  logic [3:0] w_add_hu;
  logic [7:0] w_hour12;
  logic [7:0] w_hour24;

  bcd_hour_add12 u_add12 (
    .i_ht (r_ht),
    .i_hu (r_hu),
    .o_ht (w_add_ht),
    .o_hu (w_add_hu)
  );

`ifdef DAY12_ACK_TIMEOUT_EN
  localparam logic [ACK_CNT_W-1:0] ACK_LAST = ACK_CNT_W'(ACK_TIMEOUT - 1);

  logic [ACK_CNT_W-1:0] r_ack_cnt;

  // Counts LOAD cycles without ack; cleared on the way into LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_cnt <= '0;
    end else if (r_state == ST_CONV) begin
      r_ack_cnt <= '0;
    end else if ((r_state == ST_LOAD) && !load_ack) begin
      r_ack_cnt <= r_ack_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_ack_cnt == ACK_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // 12h -> 24h mapping: 12 AM is midnight, 12 PM stays, other PM hours +12.
  always_comb begin
    w_hour12 = {r_ht, r_hu};
    if (!r_pm) begin
      w_hour24 = (w_hour12 == HOUR_NOON) ? HOUR_MIDNIGHT : w_hour12;
    end else begin
      w_hour24 = (w_hour12 == HOUR_NOON) ? HOUR_NOON : {w_add_ht, w_add_hu};
    end
  end

  // Next-state and pulse decode; ack wins over a coincident timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (is_valid_hour12(r_ht, r_hu)) begin
          w_state_nxt = ST_CONV;
        end else begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CONV: begin
        w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (load_ack) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Input capture on accept; the inputs are not looked at again afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ht <= 4'd0;
      r_hu <= 4'd0;
      r_pm <= 1'b0;
    end else if (w_capture) begin
      r_ht <= bcd_ht;
      r_hu <= bcd_hu;
      r_pm <= pm;
    end
  end

  // Result registers only move in CONV so they hold across done/err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hto <= 4'd0;
      r_huo <= 4'd0;
    end else if (r_state == ST_CONV) begin
      r_hto <= w_hour24[7:4];
      r_huo <= w_hour24[3:0];
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign load    = (r_state == ST_LOAD);
  assign done    = r_done;
  assign err     = r_err;
  assign bcd_hto = r_hto;
  assign bcd_huo = r_huo;

endmodule

// File: tb/tb_day12_24.sv
// Bench for day12_24: timeline reference model plus directed literal checks
// and a randomized phase.
module tb_day12_24;

  localparam int TB_TO = 4;
`ifdef DAY12_ACK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] bcd_ht;
  logic [3:0] bcd_hu;
  logic       pm;
  logic       load_ack;
  logic       busy;
  logic       load;
  logic       done;
  logic       err;
  logic [3:0] bcd_hto;
  logic [3:0] bcd_huo;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;
  int lit_t    = 0;
  int lit_u    = 0;

  day12_24 #(.ACK_TIMEOUT(TB_TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bcd_ht   (bcd_ht),
    .bcd_hu   (bcd_hu),
    .pm       (pm),
    .load_ack (load_ack),
    .busy     (busy),
    .load     (load),
    .done     (done),
    .err      (err),
    .bcd_hto  (bcd_hto),
    .bcd_huo  (bcd_huo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: tracks cycles elapsed since an accepted start and
  // derives the 24-hour result with plain decimal arithmetic.
  bit m_active;
  bit m_valid;
  int m_age;
  int m_res;
  bit exp_busy, exp_load, exp_done, exp_err;
  int exp_t, exp_u;

  always @(posedge clk or negedge rst_n) begin
    int hv;
    if (!rst_n) begin
      m_active = 1'b0;
      m_age    = 0;
      exp_busy = 1'b0;
      exp_load = 1'b0;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      exp_t    = 0;
      exp_u    = 0;
    end else begin
      exp_done = 1'b0;
      exp_err  = 1'b0;
      if (!m_active) begin
        if (start) begin
          hv       = int'(bcd_ht) * 10 + int'(bcd_hu);
          m_valid  = (bcd_ht <= 9) && (bcd_hu <= 9) && (hv >= 1) && (hv <= 12);
          m_res    = (hv % 12) + (pm ? 12 : 0);
          m_active = 1'b1;
          m_age    = 1;
        end
      end else begin
        m_age++;
        if (m_age == 2) begin
          if (!m_valid) begin
            m_active = 1'b0;
            exp_err  = 1'b1;
          end
        end else if (m_age == 3) begin
          exp_t = m_res / 10;
          exp_u = m_res % 10;
        end else if (m_age >= 4) begin
          if (load_ack) begin
            m_active = 1'b0;
            exp_done = 1'b1;
          end else if (TO_EN && (m_age - 3 == TB_TO)) begin
            m_active = 1'b0;
            exp_err  = 1'b1;
          end
        end
      end
      exp_busy = m_active;
      exp_load = m_active && (m_age >= 3);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("busy", busy, exp_busy);
      check("load", load, exp_load);
      check("done", done, exp_done);
      check("err", err, exp_err);
      check("bcd_hto", bcd_hto, exp_t);
      check("bcd_huo", bcd_huo, exp_u);
    end
  end

  // One directed transfer with literal checks; d = extra load cycles before ack.
  task automatic run_txn(input logic [3:0] ht, input logic [3:0] hu, input logic p,
                         input bit bad, input int d, input int et, input int eu,
                         input bit poke);
    @(negedge clk);
    bcd_ht = ht; bcd_hu = hu; pm = p; start = 1'b1;
    @(negedge clk);
    check("txn_busy_k1", busy, 1);
    start  = poke;
    bcd_ht = 4'($urandom); bcd_hu = 4'($urandom); pm = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    if (bad) begin
      check("bad_err_k2", err, 1);
      check("bad_busy_k2", busy, 0);
      check("bad_hto_hold", bcd_hto, lit_t);
      check("bad_huo_hold", bcd_huo, lit_u);
      @(negedge clk);
      check("bad_no_load", load, 0);
      return;
    end
    check("txn_load_k2", load, 0);
    @(negedge clk);
    check("txn_load_k3", load, 1);
    if (et >= 0) begin
      check("txn_hto", bcd_hto, et);
      check("txn_huo", bcd_huo, eu);
      lit_t = et;
      lit_u = eu;
    end
    start = poke;
    for (int i = 0; i < d; i++) begin
      load_ack = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check("txn_load_wait", load, 1);
    end
    load_ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("txn_done", done, 1);
    check("txn_load_off", load, 0);
    check("txn_busy_off", busy, 0);
    load_ack = 1'b0;
  endtask

  initial begin
    int et, eu;
    rst_n = 1'b0; start = 1'b0; bcd_ht = 4'd0; bcd_hu = 4'd0; pm = 1'b0; load_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_load", load, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_hto", bcd_hto, 0);
    check("rst_huo", bcd_huo, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // 12 AM with ack already high.
    load_ack = 1'b1;
    run_txn(4'd1, 4'd2, 1'b0, 1'b0, 0, 0, 0, 1'b0);

    // Reset while in LOAD, then a normal 03 PM.
    @(negedge clk);
    bcd_ht = 4'd0; bcd_hu = 4'd5; pm = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_load_before", load, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_load", load, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    check("midrst_hto", bcd_hto, 0);
    check("midrst_huo", bcd_huo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(4'd0, 4'd3, 1'b1, 1'b0, 1, 1, 5, 1'b0);

    // Sweep 01..12 AM/PM, ack two cycles after load.
    for (int h = 1; h <= 12; h++) begin
      for (int p = 0; p < 2; p++) begin
        et = -1; eu = -1;
        if (h == 9  && p == 1) begin et = 2; eu = 1; end
        if (h == 11 && p == 1) begin et = 2; eu = 3; end
        if (h == 12 && p == 1) begin et = 1; eu = 2; end
        if (h == 7  && p == 0) begin et = 0; eu = 7; end
        run_txn(4'(h / 10), 4'(h % 10), 1'(p), 1'b0, 2, et, eu, 1'b0);
      end
    end

    // Invalid hours: outputs hold the 12 PM result.
    run_txn(4'd0, 4'd0, 1'b0, 1'b1, 0, 0, 0, 1'b0);
    run_txn(4'd1, 4'd3, 1'b1, 1'b1, 0, 0, 0, 1'b0);
    run_txn(4'd0, 4'hA, 1'b0, 1'b1, 0, 0, 0, 1'b0);

    // start pokes during CHECK and LOAD are ignored.
    run_txn(4'd0, 4'd8, 1'b1, 1'b0, 1, 2, 0, 1'b1);
    @(negedge clk);
    check("poke_no_extra_busy", busy, 0);

`ifdef DAY12_ACK_TIMEOUT_EN
    @(negedge clk);
    bcd_ht = 4'd0; bcd_hu = 4'd5; pm = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < TB_TO; i++) begin
      check("to_load_held", load, 1);
      @(negedge clk);
    end
    check("to_err", err, 1);
    check("to_load_drop", load, 0);
    check("to_no_done", done, 0);
    check("to_hto_hold", bcd_hto, 0);
    check("to_huo_hold", bcd_huo, 5);
    run_txn(4'd0, 4'd6, 1'b1, 1'b0, TB_TO - 1, 1, 8, 1'b0);
`endif

    // Randomized traffic, with rare asynchronous resets.
    repeat (3000) begin
      @(negedge clk);
      start    = ($urandom_range(0, 3) == 0);
      bcd_ht   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 1));
      bcd_hu   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 9));
      pm       = 1'($urandom);
      load_ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    start = 1'b0;
    load_ack = 1'b1;
    repeat (10) @(negedge clk);
    check("drain_idle", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/day12_24.md
# day12_24

Sequential 12-hour to 24-hour BCD hour converter and loader for the BASYS2 digital clock. It accepts an hour entered in 12-hour form (BCD tens/units plus PM flag) on a start pulse and validates it. It then converts the hour to 24-hour BCD and presents it to the 24-hour hour counter through a load/acknowledge handshake. It sits between the time-set button logic and the hour counter. It is the inverse of the existing 24-to-12 display conversion path.

## Interface
- ACK_TIMEOUT, 255: cycles to wait for `load_ack` before aborting; used only when `DAY12_ACK_TIMEOUT_EN` is defined; range 1..255.
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request conversion; sampled in IDLE only.
- bcd_ht  input  4  12-hour tens digit, BCD.
- bcd_hu  input  4  12-hour units digit, BCD.
- pm  input  1  1 = PM, 0 = AM.
- load_ack  input  1  hour counter accepted `bcd_hto`/`bcd_huo`.
- busy  output  1  high from the cycle after `start` is accepted until the FSM returns to IDLE.
- load  output  1  24-hour value valid; held until acknowledged.
- done  output  1  one-cycle pulse after a successful transfer.
- err  output  1  one-cycle pulse on invalid input or timeout.
- bcd_hto  output  4  24-hour tens digit.
- bcd_huo  output  4  24-hour units digit.

## Operation
- FSM states: IDLE, CHECK, CONV, LOAD.
- IDLE: when `start`=1, capture `bcd_ht`, `bcd_hu`, `pm` into internal registers and go to CHECK. The inputs are not sampled again afterwards.
- CHECK: the captured hour is valid if both digits are ≤ 9 and the hour is 01..09, 10, 11 or 12.
  - Valid: go to CONV.
  - Invalid: pulse `err` and go to IDLE.
- CONV: register the result into `bcd_hto`/`bcd_huo`, then go to LOAD.
  - 12 AM gives 00.
  - 01–11 AM are unchanged.
  - 12 PM gives 12.
  - 01–11 PM: add 12 in BCD. Units = hu+2; if the sum is > 9, subtract 10 and set carry. Tens = ht+1+carry. Example: 09 PM → 21, 11 PM → 23.
  - All arithmetic is 4-bit per digit. Results are always in 00..23.
- LOAD: hold `load`=1 with stable data. When `load_ack`=1 at a clock edge, go to IDLE and pulse `done`.
- Boundary conditions:
  - `start` while busy: ignored.
  - `load_ack` outside LOAD: ignored.
  - `start` high in the same cycle the FSM enters IDLE: not accepted until the next cycle in IDLE.
  - `bcd_hto`/`bcd_huo` hold their last converted value after `done`, `err` and timeout. They change only in CONV.
  - Reset mid-operation: return immediately to IDLE; any pending load is discarded.
- Reset values: state IDLE; `busy`, `load`, `done`, `err` = 0; `bcd_hto`/`bcd_huo` = 0/0.

## Timing
- `start` sampled at edge k.
  - CHECK during cycle k+1 (`busy`=1).
  - CONV during cycle k+2.
  - `load`=1 with valid data from cycle k+3.
- `load_ack` sampled high at edge m: `load`=0, `busy`=0 and `done`=1 in cycle m+1. Minimum latency from `start` to `done` is 4 cycles.
- If `load_ack` is already high when `load` first rises, the transfer completes at the first LOAD edge.
- Invalid input: `err`=1 and `busy`=0 during cycle k+2. `load` never rises.
- `done` and `err` never assert in the same cycle.

## Configuration
- `DAY12_ACK_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to LOAD and increments each LOAD cycle without `load_ack`.
  - On reaching ACK_TIMEOUT, the block drops `load`, pulses `err` and returns to IDLE.
  - `load_ack` in the same cycle as the timeout takes priority: the result is `done`, not `err`.
- Not defined: LOAD waits indefinitely and no counter is synthesized.

## Structure
- Shared package `day_time_pkg` contains:
  - the FSM state encoding (IDLE, CHECK, CONV, LOAD);
  - BCD constants `HOUR_NOON` = 8'h12 and `HOUR_MIDNIGHT` = 8'h00;
  - the BCD max-digit constant 4'd9;
  - the ACK_TIMEOUT counter width.
- One combinational sub-module, `bcd_hour_add12`, performs the PM +12 BCD addition with digit carry. It is reused by the time-set logic.

## Test plan
- Reset asserted mid-LOAD → all outputs 0 and the FSM in IDLE immediately; the next `start` with 03 PM completes normally → 15.
- `start` with 12 AM, `load_ack` held high → `load` at k+3 with 0/0, `done` at k+4.
- Sweep 01–12 AM/PM, `load_ack` 2 cycles after `load` → 09 PM gives 2/1, 11 PM gives 2/3, 12 PM gives 1/2, 07 AM gives 0/7; one `done` each.
- Invalid inputs 00, 13 and units 4'hA → `err` at k+2, no `load`, `bcd_hto`/`bcd_huo` unchanged.
- `start` pulsed during CHECK and LOAD → ignored; exactly one `done` is produced.
- With `DAY12_ACK_TIMEOUT_EN` and ACK_TIMEOUT=4, no ack → `load` for 4 cycles, then `err`. Repeat with ack on the 4th cycle → `done`, no `err`.
